// File: rtl/puzzle_board_shuffler_if.sv
// Row-bus interface between the board shuffler and its consumers.
// master: drives busy/done/r1/r2/r3/blank_pos, samples start.
interface puzzle_board_shuffler_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [11:0] r1;
  logic [11:0] r2;
  logic [11:0] r3;
  logic [3:0]  blank_pos;

  modport master (
    input  start,
    output busy, done, r1, r2, r3, blank_pos
  );

  modport slave (
    output start,
    input  busy, done, r1, r2, r3, blank_pos
  );
endinterface

// File: rtl/puzzle_board_shuffler.sv
// 3x3 sliding-puzzle shuffler: random legal blank moves from solved.
// Ports: clk, rst_n (async low), bus (master: start in; busy, done,
// r1/r2/r3 rows, blank_pos out). Optional SHUFFLE_NO_UNDO_EN macro
// rejects a move that reverses the previous accepted one.
module puzzle_board_shuffler #(
  parameter int          NUM_MOVES = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  puzzle_board_shuffler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHUF,
    S_DONE
  } state_t;

  localparam logic [7:0]  NM     = 8'(NUM_MOVES);
  localparam logic [35:0] SOLVED = 36'h123456780;

  state_t           state_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [0:8][3:0]  board_q;
  logic [3:0]       blank_q;
  logic [7:0]       cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0]       dir;
  logic [1:0]       row;
  logic [1:0]       col;
  logic             legal;
  logic             undo;
  logic             accept;
  logic [3:0]       nb;

`ifdef SHUFFLE_NO_UNDO_EN
  // bit 2 marks a valid previous direction
  logic [2:0]       prev_q;
`endif

  // Fibonacci x^16+x^14+x^13+x^11+1, right shift
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                   lfsr_q[15:1]};

  always_comb begin
    dir = lfsr_q[1:0];
    case (blank_q)
      4'd0:    {row, col} = 4'h0;
      4'd1:    {row, col} = 4'h1;
      4'd2:    {row, col} = 4'h2;
      4'd3:    {row, col} = 4'h4;
      4'd4:    {row, col} = 4'h5;
      4'd5:    {row, col} = 4'h6;
      4'd6:    {row, col} = 4'h8;
      4'd7:    {row, col} = 4'h9;
      default: {row, col} = 4'hA;
    endcase
    legal = 1'b0;
    nb    = blank_q;
    unique case (dir)
      2'b00: begin
        legal = (row != 2'd0);
        nb    = blank_q - 4'd3;
      end
      2'b01: begin
        legal = (row != 2'd2);
        nb    = blank_q + 4'd3;
      end
      2'b10: begin
        legal = (col != 2'd0);
        nb    = blank_q - 4'd1;
      end
      2'b11: begin
        legal = (col != 2'd2);
        nb    = blank_q + 4'd1;
      end
    endcase
`ifdef SHUFFLE_NO_UNDO_EN
    // reverse pairs differ only in bit 0
    undo = prev_q[2] && (prev_q[1:0] == (dir ^ 2'b01));
`else
    undo = 1'b0;
`endif
    accept = legal && !undo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      board_q <= SOLVED;
      blank_q <= 4'd8;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHUFFLE_NO_UNDO_EN
      prev_q  <= 3'b000;
`endif
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          board_q <= SOLVED;
          blank_q <= 4'd8;
          cnt_q   <= 8'd0;
`ifdef SHUFFLE_NO_UNDO_EN
          prev_q  <= 3'b000;
`endif
          state_q <= S_SHUF;
        end
        S_SHUF: begin
          if (cnt_q == NM) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (accept) begin
            board_q[blank_q] <= board_q[nb];
            board_q[nb]      <= 4'h0;
            blank_q          <= nb;
            cnt_q            <= cnt_q + 8'd1;
`ifdef SHUFFLE_NO_UNDO_EN
            prev_q           <= {1'b1, dir};
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.r1        = {board_q[0], board_q[1], board_q[2]};
  assign bus.r2        = {board_q[3], board_q[4], board_q[5]};
  assign bus.r3        = {board_q[6], board_q[7], board_q[8]};
  assign bus.blank_pos = blank_q;

endmodule

// File: tb/tb_puzzle_board_shuffler.sv
// Directed bench for puzzle_board_shuffler with 0, 1 and 32 moves.
// The 32-move instance is tracked by a cycle model of the shuffler.
module tb_puzzle_board_shuffler;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic rst_n;

  int n_chk  = 0;
  int n_fail = 0;

  puzzle_board_shuffler_if b0 ();
  puzzle_board_shuffler_if b1 ();
  puzzle_board_shuffler_if b32 ();

  puzzle_board_shuffler #(.NUM_MOVES(0), .LFSR_SEED(SEED)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  puzzle_board_shuffler #(.NUM_MOVES(1), .LFSR_SEED(SEED)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  puzzle_board_shuffler #(.NUM_MOVES(32), .LFSR_SEED(SEED)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [35:0] got, logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- cycle model of the 32-move instance ----
  logic [15:0] m_l;
  logic [3:0]  mb [0:8];
  int          m_st;
  int          m_bp;
  int          m_cnt;
  int          m_prev;

  function automatic int try_move(int p, int d, int prev);
    int r = p / 3;
    int c = p % 3;
`ifdef SHUFFLE_NO_UNDO_EN
    if (prev >= 0 && (prev ^ 1) == d) return -1;
`else
    if (prev < -1) return -1;
`endif
    case (d)
      0: return (r > 0) ? p - 3 : -1;
      1: return (r < 2) ? p + 3 : -1;
      2: return (c > 0) ? p - 1 : -1;
      default: return (c < 2) ? p + 1 : -1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st   <= 0;
      m_l    <= SEED;
      mb     <= '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0};
      m_bp   <= 8;
      m_cnt  <= 0;
      m_prev <= -1;
    end else begin
      m_l <= {m_l[0] ^ m_l[2] ^ m_l[3] ^ m_l[5], m_l[15:1]};
      case (m_st)
        0: if (b32.start) m_st <= 1;
        1: begin
          mb     <= '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0};
          m_bp   <= 8;
          m_cnt  <= 0;
          m_prev <= -1;
          m_st   <= 2;
        end
        2: begin
          if (m_cnt == 32) begin
            m_st <= 3;
          end else if (try_move(m_bp, int'(m_l[1:0]), m_prev) >= 0) begin
            mb[m_bp] <= mb[try_move(m_bp, int'(m_l[1:0]), m_prev)];
            mb[try_move(m_bp, int'(m_l[1:0]), m_prev)] <= 4'h0;
            m_bp   <= try_move(m_bp, int'(m_l[1:0]), m_prev);
            m_cnt  <= m_cnt + 1;
            m_prev <= int'(m_l[1:0]);
          end
        end
        default: m_st <= 0;
      endcase
    end
  end

  function automatic logic [35:0] model_board();
    return {mb[0], mb[1], mb[2], mb[3], mb[4],
            mb[5], mb[6], mb[7], mb[8]};
  endfunction

  function automatic logic [35:0] dut_board();
    return {b32.r1, b32.r2, b32.r3};
  endfunction

  function automatic logic is_perm(logic [35:0] b);
    logic [8:0] seen = '0;
    for (int k = 0; k < 9; k++) begin
      logic [3:0] n = b[k*4 +: 4];
      if (n > 4'd8) return 1'b0;
      seen[n] = 1'b1;
    end
    return seen == 9'h1FF;
  endfunction

  function automatic logic [3:0] nib_at(logic [35:0] b, logic [3:0] p);
    logic [35:0] s = b >> (4 * (8 - int'(p)));
    return s[3:0];
  endfunction

  // ---- monitors: done pulse count, undo detection ----
  int n_done32 = 0;
  int viol     = 0;
  int last_bp  = 8;
  int last_d   = 0;
  logic last_busy = 1'b0;

  always @(negedge clk) begin
    if (b32.done) n_done32 <= n_done32 + 1;
    last_busy <= b32.busy;
    if (b32.busy && !last_busy) begin
      last_bp <= 8;
      last_d  <= 0;
    end else if (int'(b32.blank_pos) != last_bp) begin
      if (last_d != 0 &&
          int'(b32.blank_pos) - last_bp == -last_d)
        viol <= viol + 1;
      last_d  <= int'(b32.blank_pos) - last_bp;
      last_bp <= int'(b32.blank_pos);
    end
  end

  task automatic wait_done32(output int cyc);
    cyc = 1;
    while (!b32.done && cyc < 600) begin
      step();
      cyc++;
    end
    if (!b32.done) check("done32_timeout", 36'd0, 36'd1);
  endtask

  task automatic cmp_model(string tag);
    check({tag, "_board"}, dut_board(), model_board());
    check({tag, "_bp"}, 36'(b32.blank_pos), 36'(m_bp));
  endtask

  initial begin
    int cyc;
    int d0;
    logic ok;
    rst_n     = 1'b0;
    b0.start  = 1'b0;
    b1.start  = 1'b0;
    b32.start = 1'b0;
    repeat (3) step();

    check("rst_r1", 36'(b32.r1), 36'h123);
    check("rst_r2", 36'(b32.r2), 36'h456);
    check("rst_r3", 36'(b32.r3), 36'h780);
    check("rst_bp", 36'(b32.blank_pos), 36'd8);
    check("rst_busy", 36'(b32.busy), 36'd0);
    check("rst_done", 36'(b32.done), 36'd0);
    check("rst0_busy", 36'(b0.busy), 36'd0);
    rst_n = 1'b1;
    step();

    // zero moves: busy cycles 1-2, done only cycle 3
    b0.start = 1'b1;
    step();
    b0.start = 1'b0;
    check("nm0_c1_busy", 36'({b0.busy, b0.done}), 36'b10);
    step();
    check("nm0_c2_busy", 36'({b0.busy, b0.done}), 36'b10);
    step();
    check("nm0_c3_done", 36'({b0.busy, b0.done}), 36'b01);
    check("nm0_board", {b0.r1, b0.r2, b0.r3}, 36'h123456780);
    step();
    check("nm0_c4_idle", 36'({b0.busy, b0.done}), 36'b00);

    // one move
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    cyc = 1;
    while (!b1.done && cyc < 600) begin
      step();
      cyc++;
    end
    check("nm1_done_seen", 36'(b1.done), 36'd1);
    check("nm1_lat_ge4", 36'(cyc >= 4), 36'd1);
    check("nm1_r1", 36'(b1.r1), 36'h123);
    ok = (b1.r2 == 12'h450 && b1.r3 == 12'h786 && b1.blank_pos == 4'd5) ||
         (b1.r2 == 12'h456 && b1.r3 == 12'h708 && b1.blank_pos == 4'd7);
    check("nm1_board", 36'(ok), 36'd1);

    // 100 shuffles against the model
    for (int i = 0; i < 100; i++) begin
      b32.start = 1'b1;
      step();
      b32.start = 1'b0;
      wait_done32(cyc);
      cmp_model("s32");
      check("s32_lat", 36'(cyc >= 35), 36'd1);
      check("s32_perm", 36'(is_perm(dut_board())), 36'd1);
      check("s32_blank0", 36'(nib_at(dut_board(), b32.blank_pos)), 36'd0);
      repeat (1 + i % 3) step();
    end
`ifdef SHUFFLE_NO_UNDO_EN
    check("no_undo", 36'(viol), 36'd0);
`endif

    // repeated starts while busy
    d0 = n_done32;
    b32.start = 1'b1;
    step();
    cyc = 1;
    while (!b32.done && cyc < 600) begin
      b32.start = ~b32.start;
      step();
      cyc++;
    end
    b32.start = 1'b0;
    repeat (40) step();
    check("rep_one_done", 36'(n_done32 - d0), 36'd1);
    check("rep_idle", 36'(b32.busy), 36'd0);
    cmp_model("rep");

    // reset in the middle of a shuffle
    b32.start = 1'b1;
    step();
    b32.start = 1'b0;
    repeat (11) step();
    check("mid_busy_pre", 36'(b32.busy), 36'd1);
    d0 = n_done32;
    #2 rst_n = 1'b0;
    #1;
    check("mid_board", dut_board(), 36'h123456780);
    check("mid_bp", 36'(b32.blank_pos), 36'd8);
    check("mid_busy", 36'({b32.busy, b32.done}), 36'b00);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    check("mid_no_done", 36'(n_done32 - d0), 36'd0);
    b32.start = 1'b1;
    step();
    b32.start = 1'b0;
    wait_done32(cyc);
    cmp_model("post");
    check("post_perm", 36'(is_perm(dut_board())), 36'd1);
    step();
    check("post_one_done", 36'(n_done32 - d0), 36'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
